// File: rtl/uart_out.sv
// uart_out -- byte-wide 8N1 UART transmitter, LSB first, with a small
// transmit FIFO in front of the serialiser.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   FIFO_DEPTH    transmit FIFO entries (power of 2, >= 2)
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   byte_in  byte to send, taken when valid && ready
//   valid    byte_in is presented
//   ready    FIFO not full (depends only on registered count)
//   uart_tx  registered serial output, idles high
//   busy     registered: frame in progress or FIFO non-empty
module uart_out #(
   parameter int unsigned CLKS_PER_BIT = 234,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic       valid,
   output logic       ready,
   output logic       uart_tx,
   output logic       busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   logic          fifo_empty;

   // Serialiser state
   state_t        state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [7:0]    shift, shift_n;
   logic          tx_n;
   logic          baud_end;

   assign ready      = (count != FULL_CNT);
   assign push       = valid && ready;
   assign fifo_empty = (count == '0);
   assign baud_end   = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= byte_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shift    <= shift_n;
         uart_tx  <= tx_n;
         busy     <= (state != IDLE) || !fifo_empty;
      end
   end

   // The line value for the next period is decided here so uart_tx stays
   // a plain register; the FIFO head is popped straight into the shifter.
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_cnt;
      shift_n = shift;
      tx_n    = uart_tx;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            baud_n = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_n  = '0;
               bit_n   = '0;
               tx_n    = shift[0];
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_n  = '0;
               shift_n = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  bit_n = bit_cnt + 1'b1;
                  tx_n  = shift[1];
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_n = '0;
               // A waiting byte starts immediately: no idle gap between frames.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_out.sv
// tb_uart_out -- scoreboard bench for uart_out (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes are queued; a line receiver process decodes uart_tx and
// compares each frame against the queue head. Directed sections check
// exact line timing, handshake edges and reset behaviour.
module tb_uart_out;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       uart_tx;
   logic       busy;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_out #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .byte_in (byte_in),
      .valid   (valid),
      .ready   (ready),
      .uart_tx (uart_tx),
      .busy    (busy)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endfunction

   // Line receiver: sample index 0 is the first low sample of a start bit.
   int         mon_idx = 0;
   bit         mon_active = 1'b0;
   logic [7:0] mon_byte = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 1'b0;
         mon_idx    = 0;
      end else if (!mon_active) begin
         if (uart_tx === 1'b0) begin
            mon_active = 1'b1;
            mon_idx    = 0;
            mon_byte   = 8'h00;
         end
      end else begin
         mon_idx++;
         if (mon_idx == CPB/2) begin
            chk("mon start bit", uart_tx, 0);
         end else if (mon_idx > CPB && mon_idx < 9*CPB && (mon_idx % CPB) == CPB/2) begin
            mon_byte[mon_idx/CPB - 1] = uart_tx;
         end else if (mon_idx == 9*CPB + CPB/2) begin
            chk("mon stop bit", uart_tx, 1);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL mon unexpected frame: got %02h, expected no frame", mon_byte);
            end else begin
               chk("mon frame byte", mon_byte, exp_q.pop_front());
            end
         end
         if (mon_idx == 10*CPB - 1)
            mon_active = 1'b0;
      end
   end

   // Present b from the current negedge until accepted; acc = cyc after the accepting edge.
   task automatic send(input logic [7:0] b, output int acc);
      bit r;
      acc     = -1;
      byte_in = b;
      valid   = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         r = ready;
         @(negedge clk);
         if (r) begin
            acc = cyc;
            exp_q.push_back(b);
            break;
         end
      end
      valid = 1'b0;
      if (acc < 0) begin
         tests++;
         fails++;
         $display("FAIL send timeout: byte %02h not accepted, expected acceptance", b);
      end
   endtask

   // Check one full frame cycle by cycle; now=1 means the current sample is its first cycle.
   task automatic check_frame(input logic [7:0] b, input bit now);
      logic want;
      int   k;
      for (int i = 0; i < 10*CPB; i++) begin
         if (i > 0 || !now) @(negedge clk);
         k = i / CPB;
         if (k == 0)      want = 1'b0;
         else if (k == 9) want = 1'b1;
         else             want = b[k-1];
         chk($sformatf("line %02h bit %0d", b, k), uart_tx, want);
         chk($sformatf("busy in frame %02h", b), busy, 1);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && busy !== 1'b0; i++) @(negedge clk);
      chk("busy drops", busy, 0);
      repeat (2) @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 0);
   endtask

   task automatic wait_cyc(input int target);
      for (int i = 0; i < 500 && cyc < target; i++) @(negedge clk);
      chk("reached cycle", cyc, target);
   endtask

   task automatic watch_idle_line(input string name, input int n);
      bit saw_low;
      saw_low = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) saw_low = 1'b1;
      end
      chk(name, saw_low, 0);
   endtask

   initial begin
      int a [6];

      // Reset
      repeat (3) @(negedge clk);
      chk("reset uart_tx", uart_tx, 1);
      chk("reset ready", ready, 1);
      chk("reset busy", busy, 0);
      #2 rst_n = 1'b1;
      watch_idle_line("idle line after reset", 100);
      chk("idle ready", ready, 1);
      chk("idle busy", busy, 0);

      // Single byte
      send(8'h41, a[0]);
      chk("tx idle on accept edge", uart_tx, 1);
      check_frame(8'h41, 1'b0);
      @(negedge clk);
      chk("busy one cycle after frame", busy, 1);
      chk("line idle after frame", uart_tx, 1);
      @(negedge clk);
      chk("busy cleared", busy, 0);
      wait_idle();

      // Back-to-back frames, no gap
      send(8'h55, a[0]);
      send(8'hAA, a[1]);
      chk("b2b consecutive accept", a[1], a[0] + 1);
      check_frame(8'h55, 1'b1);
      check_frame(8'hAA, 1'b0);
      wait_idle();

      // Full FIFO
      for (int i = 0; i < 5; i++) send(8'(i + 1), a[i]);
      chk("ready low when full", ready, 0);
      send(8'h06, a[5]);
      for (int i = 1; i < 5; i++) chk($sformatf("full accept edge %0d", i), a[i], a[0] + i);
      chk("byte 06 accept edge", a[5], a[0] + 10*CPB + 2);
      wait_idle();

      // Reset mid-frame during D3 of 0xF0
      send(8'hF0, a[0]);
      send(8'h12, a[1]);
      send(8'h34, a[2]);
      wait_cyc(a[0] + 4*CPB + 2);
      chk("D3 low before reset", uart_tx, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset uart_tx", uart_tx, 1);
      chk("async reset ready", ready, 1);
      chk("async reset busy", busy, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      watch_idle_line("no frames after reset", 100);
      chk("ready after reset", ready, 1);
      chk("busy after reset", busy, 0);

      // Push on the STOP-state pop edge
      send(8'h11, a[0]);
      send(8'h22, a[1]);
      send(8'h33, a[2]);
      wait_cyc(a[0] + 10*CPB);
      send(8'h44, a[3]);
      chk("push on pop edge", a[3], a[0] + 10*CPB + 1);
      chk("count unchanged on push+pop", dut.count, 2);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
